// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared FSM encoding, column drive patterns and defaults for the hex keypad scanner
package keypad_pkg;

  localparam int SCAN_DIV_DEFAULT       = 256;
  localparam int DEBOUNCE_SCANS_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] COL_DRIVE_0 = 4'b0111;
  localparam logic [3:0] COL_DRIVE_1 = 4'b1011;
  localparam logic [3:0] COL_DRIVE_2 = 4'b1101;
  localparam logic [3:0] COL_DRIVE_3 = 4'b1110;

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    logic [3:0] pat;
    pat = COL_DRIVE_0;
    case (c)
      2'd0: pat = COL_DRIVE_0;
      2'd1: pat = COL_DRIVE_1;
      2'd2: pat = COL_DRIVE_2;
      2'd3: pat = COL_DRIVE_3;
      default: pat = COL_DRIVE_0;
    endcase
    return pat;
  endfunction

  // Returns {hit, row_index}; a hit needs exactly one active-low row.
  function automatic logic [2:0] row_decode(input logic [3:0] rows);
    logic [2:0] res;
    res = 3'b000;
    case (rows)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/scan_tick.sv
// rtl/scan_tick.sv - free-running column scan divider, tick on the wrap cycle
module scan_tick
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/hex_keypad_entry.sv
// rtl/hex_keypad_entry.sv - 4x4 hex keypad scanner with debounce and 4-digit entry shift register; KEYPAD_ENTER_KEY_EN makes key F an enter key
module hex_keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        clear,
  output logic [15:0] data_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        entry_strobe
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);

  logic tick;

  scan_tick #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [15:0]      data_q, data_d;
  logic             key_valid_q, key_valid_d;

  logic [2:0]       row_info;
  logic             hit;
  logic [3:0]       sample_code;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             is_enter;
  logic             shift_en;

  assign row_info    = row_decode(row_in);
  assign hit         = row_info[2];
  assign sample_code = {row_info[1:0], col_q};
  assign cnt_inc     = cnt_q + CNT_W'(1);

  // Scan/debounce FSM: only ticks move it; the column is frozen outside IDLE.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    accept  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            code_d = sample_code;
            cnt_d  = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_d = ST_HELD;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (hit && (sample_code == code_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              accept  = 1'b1;
              state_d = ST_HELD;
            end
          end else begin
            state_d = ST_IDLE;
            col_d   = col_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (!hit) begin
            cnt_d = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = ST_IDLE;
              col_d   = col_q + 2'd1;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (hit) begin
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_d = ST_IDLE;
              col_d   = col_q + 2'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifdef KEYPAD_ENTER_KEY_EN
  localparam logic [3:0] ENTER_CODE = 4'hF;
  assign is_enter = (sample_code == ENTER_CODE);
`else
  assign is_enter = 1'b0;
`endif

  assign shift_en = accept && !is_enter;

  always_comb begin
    key_valid_d = accept;
    key_code_d  = key_code_q;
    data_d      = data_q;
    if (accept) begin
      key_code_d = sample_code;
    end
    // A coinciding clear discards the old digits but keeps the new one.
    if (clear) begin
      data_d = shift_en ? {12'h000, sample_code} : 16'h0000;
    end else if (shift_en) begin
      data_d = {data_q[11:0], sample_code};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      col_q       <= 2'd0;
      cnt_q       <= '0;
      code_q      <= 4'h0;
      key_code_q  <= 4'h0;
      data_q      <= 16'h0000;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      key_code_q  <= key_code_d;
      data_q      <= data_d;
      key_valid_q <= key_valid_d;
    end
  end

`ifdef KEYPAD_ENTER_KEY_EN
  logic entry_q, entry_d;

  assign entry_d = accept && is_enter;

  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_strobe = entry_q;
`else
  assign entry_strobe = 1'b0;
`endif

  assign col_out   = col_drive(col_q);
  assign data_out  = data_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule
